// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC / instruction-fetch sequencer.
// Holds the FSM state encoding and the latency-counter width helper.
// Imported by pc_fetch and pc_reg.
package pc_fetch_pkg;

  // FSM state encoding, kept as plain constants so older tools can consume it
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FETCH = 2'd0;
  localparam fetch_state_t WAIT  = 2'd1;
  localparam fetch_state_t HOLD  = 2'd2;

  // Bits needed to represent values 0..v-1; used as clog2(MEM_LAT+1) so the
  // latency counter can hold MEM_LAT itself.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async reset to RESET_ADDR, load has priority over inc.
// Latency: new value visible one cycle after load/inc.
// No handshake; wraps silently from all-ones to zero.
module pc_reg
  import pc_fetch_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] in,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // PC update: reset > load > increment (natural modulo-2^ADDR_W wrap)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_ADDR;
    end else if (load) begin
      pc <= in;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// PC + fetch sequencer: reads a synchronous instruction memory and presents the word on valid/ready.
// Latency: MEM_LAT+1 cycles from mem_rd to instr_valid; one word per MEM_LAT+2 cycles at best.
// Backpressure: instr is held in HOLD until instr_ready; no new read is issued meanwhile.
// Optional feature macro: PC_FETCH_HALT_EN adds a 'halt' input that stalls new fetches.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                MEM_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] in,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef PC_FETCH_HALT_EN
  ,
  input  logic              halt
`endif
);

  localparam int              CNT_W    = clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);

  fetch_state_t     state;
  logic [CNT_W-1:0] lat_cnt;
  logic             halt_req;
  logic             handshake;
  logic             pc_inc;

`ifdef PC_FETCH_HALT_EN
  assign halt_req = halt;
`else
  assign halt_req = 1'b0;
`endif

  // Word is consumed when it is presented and downstream takes it.
  assign handshake = (state == HOLD) && instr_valid && instr_ready;
  // A jump in the same cycle consumes the word but overrides the increment.
  assign pc_inc    = handshake && !load;

  // The address is always the PC; a read is only launched from FETCH, so at most
  // one read is ever outstanding. Gated by reset so outputs are quiet while held.
  assign mem_addr = pc;
  assign mem_rd   = !reset && (state == FETCH) && !load && !halt_req;

  pc_reg #(
    .ADDR_W     (ADDR_W),
    .RESET_ADDR (RESET_ADDR)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (reset),
    .load (load),
    .in   (in),
    .inc  (pc_inc),
    .pc   (pc)
  );

  // Fetch FSM: FETCH issues the read, WAIT counts out memory latency and
  // captures the word, HOLD presents it until accepted. A jump restarts in FETCH
  // and drops any word pending or presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      lat_cnt     <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else if (load) begin
      state       <= FETCH;
      lat_cnt     <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (!halt_req) begin
            state   <= WAIT;
            lat_cnt <= CNT_ONE;
          end
        end
        WAIT: begin
          if (lat_cnt == CNT_LAST) begin
            instr       <= mem_data;
            instr_valid <= 1'b1;
            state       <= HOLD;
            lat_cnt     <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: begin
          state       <= FETCH;
          lat_cnt     <= '0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: two instances (RESET_ADDR 0 and 16'hFFFF), each with
// a one-cycle-latency memory returning addr ^ 16'hA5A5.
// Halt checks are compiled in when PC_FETCH_HALT_EN is defined.
module tb_pc_fetch;

  logic        clk;
  logic        rst_a, load_a, ready_a, halt_a;
  logic [15:0] in_a, pc_a, addr_a, mdata_a, instr_a;
  logic        rd_a, valid_a;

  logic        rst_b, load_b, ready_b, halt_b;
  logic [15:0] in_b, pc_b, addr_b, mdata_b, instr_b;
  logic        rd_b, valid_b;

  int n_chk;
  int n_pass;

  pc_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_ADDR(16'h0000), .MEM_LAT(1)) dut_a (
    .clk(clk), .reset(rst_a), .load(load_a), .in(in_a), .pc(pc_a),
    .mem_addr(addr_a), .mem_rd(rd_a), .mem_data(mdata_a),
    .instr(instr_a), .instr_valid(valid_a), .instr_ready(ready_a)
`ifdef PC_FETCH_HALT_EN
    , .halt(halt_a)
`endif
  );

  pc_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_ADDR(16'hFFFF), .MEM_LAT(1)) dut_b (
    .clk(clk), .reset(rst_b), .load(load_b), .in(in_b), .pc(pc_b),
    .mem_addr(addr_b), .mem_rd(rd_b), .mem_data(mdata_b),
    .instr(instr_b), .instr_valid(valid_b), .instr_ready(ready_b)
`ifdef PC_FETCH_HALT_EN
    , .halt(halt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous memories, one cycle of read latency
  always @(posedge clk) begin
    if (rd_a) mdata_a <= addr_a ^ 16'hA5A5;
    if (rd_b) mdata_b <= addr_b ^ 16'hA5A5;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_a = 1'b1; load_a = 1'b0; in_a = '0; ready_a = 1'b1; halt_a = 1'b0;
    rst_b = 1'b1; load_b = 1'b0; in_b = '0; ready_b = 1'b1; halt_b = 1'b0;
    mdata_a = '0; mdata_b = '0;

    // reset state
    #3;
    chk("rst_pc", pc_a, 16'h0000);
    chk("rst_instr", instr_a, 16'h0000);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_mem_rd", rd_a, 1'b0);
    chk("rst_pc_b", pc_b, 16'hFFFF);

    // 1: streaming with ready=1
    step(); rst_a = 1'b0; #1;                      // cycle 0
    chk("c0_mem_rd", rd_a, 1'b1);
    chk("c0_addr", addr_a, 16'h0000);
    step();                                        // cycle 1
    chk("c1_mem_rd", rd_a, 1'b0);
    chk("c1_valid", valid_a, 1'b0);
    step();                                        // cycle 2
    chk("c2_valid", valid_a, 1'b1);
    chk("c2_instr", instr_a, 16'hA5A5);
    chk("c2_pc", pc_a, 16'h0000);
    step();                                        // cycle 3
    chk("c3_mem_rd", rd_a, 1'b1);
    chk("c3_pc", pc_a, 16'h0001);
    chk("c3_valid", valid_a, 1'b0);
    step(); step();                                // cycle 5
    chk("c5_instr", instr_a, 16'hA5A4);
    step();                                        // cycle 6
    chk("c6_mem_rd", rd_a, 1'b1);
    chk("c6_pc", pc_a, 16'h0002);
    step(); step();                                // cycle 8

    // 2: backpressure in HOLD for 5 cycles
    ready_a = 1'b0; #1;
    chk("c8_instr", instr_a, 16'hA5A7);
    chk("c8_valid", valid_a, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_instr", instr_a, 16'hA5A7);
      chk("bp_valid", valid_a, 1'b1);
      chk("bp_mem_rd", rd_a, 1'b0);
      chk("bp_pc", pc_a, 16'h0002);
    end
    ready_a = 1'b1;                                // cycle 13
    step();                                        // cycle 14
    chk("acc_pc", pc_a, 16'h0003);
    chk("acc_valid", valid_a, 1'b0);
    chk("acc_mem_rd", rd_a, 1'b1);

    // 3: jump during WAIT drops the pending word
    step();                                        // cycle 15
    load_a = 1'b1; in_a = 16'h0040; #1;
    chk("jw_mem_rd", rd_a, 1'b0);
    step(); load_a = 1'b0; #1;                     // cycle 16
    chk("jw_pc", pc_a, 16'h0040);
    chk("jw_valid", valid_a, 1'b0);
    chk("jw_mem_rd", rd_a, 1'b1);
    chk("jw_addr", addr_a, 16'h0040);
    step();                                        // cycle 17
    chk("jw_valid2", valid_a, 1'b0);
    step();                                        // cycle 18
    chk("jw_instr", instr_a, 16'hA5E5);
    chk("jw_valid3", valid_a, 1'b1);

    // 4: jump together with a HOLD handshake
    load_a = 1'b1; in_a = 16'h0100;
    step(); load_a = 1'b0; #1;                     // cycle 19
    chk("jh_pc", pc_a, 16'h0100);
    chk("jh_valid", valid_a, 1'b0);
    chk("jh_addr", addr_a, 16'h0100);
    chk("jh_mem_rd", rd_a, 1'b1);
    step(); step();                                // cycle 21
    chk("jh_instr", instr_a, 16'hA4A5);

    // jump in FETCH suppresses the read
    step();                                        // cycle 22
    chk("jf_pc", pc_a, 16'h0101);
    load_a = 1'b1; in_a = 16'h0200; #1;
    chk("jf_mem_rd", rd_a, 1'b0);
    step(); load_a = 1'b0; #1;                     // cycle 23
    chk("jf_pc2", pc_a, 16'h0200);

`ifdef PC_FETCH_HALT_EN
    // 6: halt for 3 cycles in FETCH
    halt_a = 1'b1; #1;
    chk("halt_rd0", rd_a, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("halt_rd", rd_a, 1'b0);
      chk("halt_pc", pc_a, 16'h0200);
    end
    step(); halt_a = 1'b0; #1;                     // cycle 26
    chk("unhalt_rd", rd_a, 1'b1);
    chk("unhalt_addr", addr_a, 16'h0200);
    step();
    chk("unhalt_wait", rd_a, 1'b0);
`else
    chk("nohalt_rd", rd_a, 1'b1);
`endif

    // 5: wrap from 16'hFFFF and async reset mid-WAIT
    step(); rst_b = 1'b0; #1;                      // b cycle 0
    chk("w_mem_rd", rd_b, 1'b1);
    chk("w_addr", addr_b, 16'hFFFF);
    step(); step();                                // b cycle 2
    chk("w_instr", instr_b, 16'h5A5A);
    chk("w_valid", valid_b, 1'b1);
    step();                                        // b cycle 3
    chk("w_pc", pc_b, 16'h0000);
    chk("w_addr0", addr_b, 16'h0000);
    step();                                        // b cycle 4, WAIT
    chk("w_wait_valid", valid_b, 1'b0);
    rst_b = 1'b1; #1;                              // no clock edge in between
    chk("ar_pc", pc_b, 16'hFFFF);
    chk("ar_instr", instr_b, 16'h0000);
    chk("ar_valid", valid_b, 1'b0);
    chk("ar_mem_rd", rd_b, 1'b0);
    step(); step(); rst_b = 1'b0; #1;
    chk("ar_restart_rd", rd_b, 1'b1);
    chk("ar_restart_addr", addr_b, 16'hFFFF);
    step(); step();
    chk("ar_restart_instr", instr_b, 16'h5A5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
